// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port byte-RAM read arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    ACK   = 2'd3
  } state_e;

  localparam int PORT_IFETCH = 0;
  localparam int PORT_DATA   = 1;

  localparam int AW_DEF     = 8;
  localparam int NBYTES_DEF = 4;

endpackage

// File: rtl/mem_read_arbiter_rr_arb2.sv
// Two-input round-robin grant: on a tie the port not granted last time wins.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic       upd_gnt_i,
  output logic       vld_o,
  output logic       gnt_o
);

  logic last_q;

  // Reset to the data port so the fetch port wins the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    last_q <= 1'b1;
    else if (upd_i) last_q <= upd_gnt_i;
  end

  always_comb begin
    vld_o = |req_i;
    gnt_o = 1'(PORT_IFETCH);
    if (&req_i)        gnt_o = ~last_q;
    else if (req_i[1]) gnt_o = 1'(PORT_DATA);
  end

endmodule

// File: rtl/mem_read_arbiter.sv
// Shares one byte-wide synchronous RAM between two word readers; each grant
// becomes NBYTES sequential byte reads assembled little-endian and acked once.
module mem_read_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int NBYTES = NBYTES_DEF
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req0_i,
  input  logic [AW-1:0]       addr0_i,
  input  logic                req1_i,
  input  logic [AW-1:0]       addr1_i,
  output logic                ack0_o,
  output logic                ack1_o,
  output logic [8*NBYTES-1:0] rdata_o,
  output logic                busy_o,
  output logic                ram_rd_en_o,
  output logic [AW-1:0]       ram_addr_o,
  input  logic [7:0]          ram_rdata_i
);

  localparam int            CW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  state_e                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cap_idx_q;
  logic [AW-1:0]            base_q, ram_addr_q, win_addr;
  logic                     gnt_q, cap_vld_q, rd_en_q, busy_q;
  logic [1:0]               ack_q;
  logic [NBYTES-1:0][7:0]   rdata_q;
  logic                     arb_vld, arb_gnt;

  rr_arb2 u_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     ({req1_i, req0_i}),
    .upd_i     (state_q == ACK),
    .upd_gnt_i (gnt_q),
    .vld_o     (arb_vld),
    .gnt_o     (arb_gnt)
  );

  assign win_addr = arb_gnt ? addr1_i : addr0_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_vld) state_d = FETCH;
      FETCH:   if (cnt_q == LAST) state_d = DRAIN;
      DRAIN:   state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address/strobe are registered so ram_addr already equals base+cnt while cnt_q holds.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      base_q     <= '0;
      gnt_q      <= 1'b0;
      rd_en_q    <= 1'b0;
      ram_addr_q <= '0;
      cap_vld_q  <= 1'b0;
      cap_idx_q  <= '0;
      ack_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      busy_q    <= (state_d != IDLE);
      cap_vld_q <= rd_en_q;
      cap_idx_q <= cnt_q;
      ack_q     <= '0;
      case (state_q)
        IDLE: begin
          if (arb_vld) begin
            base_q     <= win_addr;
            gnt_q      <= arb_gnt;
            cnt_q      <= '0;
            rd_en_q    <= 1'b1;
            ram_addr_q <= win_addr;
          end
        end
        FETCH: begin
          if (cnt_q == LAST) begin
            rd_en_q <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q      <= cnt_q + 1'b1;
            ram_addr_q <= base_q + AW'(cnt_q) + AW'(1);
          end
        end
        DRAIN:   ack_q[gnt_q] <= 1'b1;
        default: ;
      endcase
    end
  end

  // Read data lags its address cycle by one; the byte lands on the edge after that.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else begin
      for (int k = 0; k < NBYTES; k++)
        if (cap_vld_q && cap_idx_q == CW'(k)) rdata_q[k] <= ram_rdata_i;
    end
  end

  assign ack0_o      = ack_q[PORT_IFETCH];
  assign ack1_o      = ack_q[PORT_DATA];
  assign rdata_o     = rdata_q;
  assign busy_o      = busy_q;
  assign ram_rd_en_o = rd_en_q;
  assign ram_addr_o  = ram_addr_q;

endmodule

// File: doc/mem_read_arbiter.md
# mem_read_arbiter

Shares one synchronous byte-wide RAM between two 32-bit read requesters, the instruction-fetch port and the data-load port of the ALU core. Each granted request becomes four sequential byte reads, assembled little-endian into one word and returned with a one-cycle acknowledge. Arbitration between the two ports is round-robin. The block sits between the ALU core's `readReq`/`ramAddress`/`readAck`/`ramValue` handshake and the RAM macro.

## Interface
Parameters:
- `AW`, 8: byte-address width; addresses wrap modulo 2^AW.
- `NBYTES`, 4: bytes per returned word; data width is 8*NBYTES.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req0`  in  1  port 0 (instruction fetch) read request.
- `addr0`  in  AW  port 0 byte address; stable while `req0` is high.
- `req1`  in  1  port 1 (data load) read request.
- `addr1`  in  AW  port 1 byte address; stable while `req1` is high.
- `ack0`  out  1  one-cycle pulse; port 0 word valid on `rdata`.
- `ack1`  out  1  one-cycle pulse; port 1 word valid on `rdata`.
- `rdata`  out  8*NBYTES  assembled word; byte k is read from base+k. Holds until the next word completes.
- `busy`  out  1  high in every state except IDLE.
- `ram_rd_en`  out  1  RAM read strobe.
- `ram_addr`  out  AW  RAM byte address.
- `ram_rdata`  in  8  RAM read data, valid one cycle after the address/strobe cycle.

## Operation
- FSM states: IDLE, FETCH, DRAIN, ACK.
  - IDLE: sample `req0`/`req1`. If any request is high, latch the winner's address into `base` and the winner's index into `gnt`, set `cnt`=0, and go to FETCH.
  - FETCH: drive `ram_rd_en`=1 and `ram_addr`=base+cnt, truncated to AW bits. `cnt` increments each cycle. After `cnt`=NBYTES-1, go to DRAIN.
  - DRAIN: `ram_rd_en`=0; capture the last byte; go to ACK.
  - ACK: assert `ack[gnt]`=1 for exactly one cycle; update `last_gnt`=`gnt`; go to IDLE.
- Byte capture: the byte returned for read k (data valid one cycle after its address cycle) is written to `rdata[8k+7:8k]` on the following edge. `rdata` is updated only by captures; `rdata` keeps the previous word until the new word's bytes overwrite it.
- Arbitration, applied in IDLE only:
  - Only one requester high: grant it.
  - Both high: grant the port that is not `last_gnt`.
  - `last_gnt` resets to 1, so port 0 wins the first tie.
- Requests are not re-sampled between grant and ACK. Dropping `req` mid-transaction is a protocol violation; the transaction still completes and acks.
- A requester must deassert `req` on the edge where it sees its ack, unless it wants another word. A `req` still high in the following IDLE cycle is treated as a new request.
- Address wrap: base 0xFE with AW=8 reads 0xFE, 0xFF, 0x00, 0x01.
- Reset (asserted at any time, including mid-FETCH):
  - state=IDLE, `cnt`=0, `last_gnt`=1, `rdata`=0.
  - All outputs 0: `ack0`, `ack1`, `busy`, `ram_rd_en`, `ram_addr`.
  - No ack is issued for an interrupted transaction.

## Timing
- Request sampled at edge E0 in IDLE.
- FETCH occupies cycles E0–E4 (one read per cycle, NBYTES=4).
- DRAIN occupies E4–E5.
- ACK is high during E5–E6.
- Latency from the sampling edge to ack: NBYTES+1 cycles.
- The earliest next sampling edge is E7. A continuously requesting port therefore gets one word per NBYTES+3 cycles.
- With both ports held high, grants alternate strictly: 0, 1, 0, 1, …
- All outputs are registered; there are no combinational paths from `req`/`addr` to outputs.

## Structure
- Shared package `mem_arb_pkg`:
  - State enum (IDLE, FETCH, DRAIN, ACK).
  - Port-index constants (PORT_IFETCH=0, PORT_DATA=1).
  - Default AW/NBYTES.
- One sub-module, `rr_arb2`: two-input round-robin grant logic with the `last_gnt` register and an update strobe. It is the only natural split.
- FSM, counter and byte assembly stay in the top module.

## Test plan
- Single port 0 read: mem[0x10..0x13]=11,22,33,44; `req0`=1, `addr0`=0x10.
  - Required: `ram_addr` sequence 10,11,12,13; `ack0` pulses 5 cycles after sampling; `rdata`=0x44332211; `ack1` stays 0.
- Simultaneous requests from reset: `req0`/`addr0`=0x00 and `req1`/`addr1`=0x20, both held.
  - Required: port 0 granted first, then port 1, then port 0; ack order 0, 1, 0; each `rdata` matches its own address.
- Wrap-around: mem[0xFE]=AA, mem[0xFF]=BB, mem[0x00]=CC, mem[0x01]=DD; `addr1`=0xFE.
  - Required: `ram_addr` sequence FE,FF,00,01; `rdata`=0xDDCCBBAA.
- Reset mid-FETCH: apply `reset`=0 while `cnt`=2.
  - Required: all outputs 0 immediately (asynchronous); no ack afterwards.
  - After release, a fresh `req0` completes normally with correct data.
- Held request after ack: `req1` kept high across ack.
  - Required: a second read of the same address starts at the next IDLE edge; `busy` low for exactly one cycle between transactions.
